// File: rtl/display_varredura_n_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver: blank pattern,
// BCD glyph table and the width helper used to size the scan counters.
package display_pkg;

    localparam logic [7:0] SEG_APAGADO = 8'hFF;

    // Bit order per entry is {a,b,c,d,e,f,g,dp}, active-low; glyph d lives at [8*d +: 8].
    localparam logic [79:0] GLIFOS_BCD = {
        8'b0000100_1,  // 9
        8'b0000000_1,  // 8
        8'b0001111_1,  // 7
        8'b0100000_1,  // 6
        8'b0100100_1,  // 5
        8'b1001100_1,  // 4
        8'b0000110_1,  // 3
        8'b0010010_1,  // 2
        8'b1001111_1,  // 1
        8'b0000001_1   // 0
    };

    function automatic int clog2(input int valor);
        int largura;
        largura = 1;
        while ((1 << largura) < valor) begin
            largura++;
        end
        return largura;
    endfunction

endpackage

// File: rtl/display_varredura_n_if.sv
// Pin-side bundle of the scan driver: control/data from the counting datapath in,
// registered segment and digit-enable lines out.
interface display_varredura_n_if #(
    parameter int N_DIGITS = 4
);
    logic                    ligado;
    logic [4*N_DIGITS-1:0]   valores;
    logic [N_DIGITS-1:0]     pontos;
    logic [7:0]              segmentos;
    logic [N_DIGITS-1:0]     digitos;
    logic                    quadro_fim;

    modport master (
        output ligado, valores, pontos,
        input  segmentos, digitos, quadro_fim
    );

    modport slave (
        input  ligado, valores, pontos,
        output segmentos, digitos, quadro_fim
    );

endinterface

// File: rtl/display_varredura_n_dec.sv
// Combinational BCD to active-low 7-segment glyph {a..g}; codes 10..15 come out blank.
module seg7_bcd_dec
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glifo
);

    int indice;

    always_comb begin
        indice = int'(bcd);
        glifo  = SEG_APAGADO[7:1];
        if (bcd <= 4'd9) begin
            glifo = GLIFOS_BCD[8*indice+1 +: 7];
        end
    end

endmodule

// File: rtl/display_varredura_n.sv
// Self-timed N-digit common-anode scan driver with per-frame snapshot and dead time.
// Optional leading-zero blanking is compiled in with ZEROS_ESQUERDA_APAGA_EN.
module display_varredura_n
    import display_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    display_varredura_n_if.slave   bus
);

    localparam int CNT_W = clog2(PRESCALE);
    localparam int IDX_W = clog2(N_DIGITS);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   valores_q, valores_d;
    logic [N_DIGITS-1:0]     pontos_q, pontos_d;
    logic [7:0]              segmentos_q, segmentos_d;
    logic [N_DIGITS-1:0]     digitos_q, digitos_d;
    logic                    quadro_fim_q, quadro_fim_d;

    logic [3:0]              bcd_sel;
    logic                    ponto_sel;
    logic                    apaga_sel;
    logic [N_DIGITS-1:0]     digito_sel;
    logic [N_DIGITS-1:0]     zero_esq;
    logic [6:0]              glifo;

    // Prescaler, digit index and frame snapshot; ligado=0 parks the scan at slot 0.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        valores_d    = valores_q;
        pontos_d     = pontos_q;
        quadro_fim_d = 1'b0;
        if (!bus.ligado) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            if (idx_q == '0 && cnt_q == '0) begin
                valores_d = bus.valores;
                pontos_d  = bus.pontos;
            end
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (idx_q == IDX_MAX) begin
                    idx_d        = '0;
                    quadro_fim_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef ZEROS_ESQUERDA_APAGA_EN
    logic zeros_acima;

    // zero_esq[i] is indexed by digit number; the last digit is never blanked.
    always_comb begin
        zeros_acima = 1'b1;
        zero_esq    = '0;
        for (int i = 0; i < N_DIGITS - 1; i++) begin
            zeros_acima = zeros_acima & (valores_q[4*(N_DIGITS-1-i) +: 4] == 4'd0);
            zero_esq[i] = zeros_acima;
        end
    end
`else
    assign zero_esq = '0;
`endif

    // Digit 0 is the leftmost digit and maps to the MSB of valores, pontos and digitos.
    always_comb begin
        bcd_sel    = '0;
        ponto_sel  = 1'b0;
        apaga_sel  = 1'b0;
        digito_sel = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                bcd_sel                   = valores_q[4*(N_DIGITS-1-i) +: 4];
                ponto_sel                 = pontos_q[N_DIGITS-1-i];
                apaga_sel                 = zero_esq[i];
                digito_sel[N_DIGITS-1-i]  = 1'b0;
            end
        end
    end

    seg7_bcd_dec u_dec (
        .bcd   (bcd_sel),
        .glifo (glifo)
    );

    always_comb begin
        segmentos_d = SEG_APAGADO;
        digitos_d   = '1;
        if (bus.ligado && cnt_q >= DEAD_LIM) begin
            digitos_d   = digito_sel;
            segmentos_d = {(apaga_sel ? SEG_APAGADO[7:1] : glifo), ~ponto_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            valores_q    <= '0;
            pontos_q     <= '0;
            segmentos_q  <= SEG_APAGADO;
            digitos_q    <= '1;
            quadro_fim_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            valores_q    <= valores_d;
            pontos_q     <= pontos_d;
            segmentos_q  <= segmentos_d;
            digitos_q    <= digitos_d;
            quadro_fim_q <= quadro_fim_d;
        end
    end

    assign bus.segmentos  = segmentos_q;
    assign bus.digitos    = digitos_q;
    assign bus.quadro_fim = quadro_fim_q;

endmodule

// File: tb/tb_display_varredura_n.sv
// Directed bench for display_varredura_n with N_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1;
// expectations follow ZEROS_ESQUERDA_APAGA_EN when it is defined for the build.
module tb_display_varredura_n;

    localparam int N = 4;

    // Expected segment bytes {a..g,dp}, active-low.
    localparam logic [7:0] S_BLANK  = 8'hFF;
    localparam logic [7:0] S_1      = 8'h9F;
    localparam logic [7:0] S_2_DP   = 8'h24;
    localparam logic [7:0] S_3      = 8'h0D;
    localparam logic [7:0] S_4      = 8'h99;
    localparam logic [7:0] S_5      = 8'h49;
    localparam logic [7:0] S_6_DP   = 8'h40;
    localparam logic [7:0] S_7      = 8'h1F;
    localparam logic [7:0] S_8      = 8'h01;
    localparam logic [7:0] S_0      = 8'h03;
    localparam logic [7:0] S_BL_DP  = 8'hFE;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    display_varredura_n_if #(.N_DIGITS(N)) bus ();

    display_varredura_n #(
        .N_DIGITS    (N),
        .PRESCALE    (4),
        .DEAD_CYCLES (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic confere(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pinos(input string tag, input logic [3:0] dig, input logic [7:0] seg, input logic fim);
        confere({tag, "/dig"}, 32'(bus.digitos), 32'(dig));
        confere({tag, "/seg"}, 32'(bus.segmentos), 32'(seg));
        confere({tag, "/fim"}, 32'(bus.quadro_fim), 32'(fim));
        confere({tag, "/overlap"}, 32'($countones(~bus.digitos) <= 1), 32'd1);
    endtask

    task automatic slot(input string tag, input logic [3:0] dig, input logic [7:0] seg, input logic fim_last);
        tick();
        pinos({tag, "/dead"}, 4'b1111, S_BLANK, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            pinos(tag, dig, seg, (j == 2) ? fim_last : 1'b0);
        end
    endtask

    task automatic quadro(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3);
        slot({tag, "/d0"}, 4'b0111, s0, 1'b0);
        slot({tag, "/d1"}, 4'b1011, s1, 1'b0);
        slot({tag, "/d2"}, 4'b1101, s2, 1'b0);
        slot({tag, "/d3"}, 4'b1110, s3, 1'b1);
    endtask

    initial begin
        reset       = 1'b1;
        bus.ligado  = 1'b1;
        bus.valores = 16'h1234;
        bus.pontos  = 4'b0100;

        repeat (3) begin
            tick();
            pinos("reset", 4'b1111, S_BLANK, 1'b0);
        end
        reset = 1'b0;

        quadro("f1234a", S_1, S_2_DP, S_3, S_4);
        quadro("f1234b", S_1, S_2_DP, S_3, S_4);

        // New value arrives while idx=2: the running frame keeps its snapshot.
        slot("mid/d0", 4'b0111, S_1, 1'b0);
        slot("mid/d1", 4'b1011, S_2_DP, 1'b0);
        bus.valores = 16'h5678;
        slot("mid/d2", 4'b1101, S_3, 1'b0);
        slot("mid/d3", 4'b1110, S_4, 1'b1);
        quadro("f5678", S_5, S_6_DP, S_7, S_8);

        bus.valores = 16'h00A7;
        bus.pontos  = 4'b0010;
`ifdef ZEROS_ESQUERDA_APAGA_EN
        quadro("f00A7", S_BLANK, S_BLANK, S_BL_DP, S_7);
`else
        quadro("f00A7", S_0, S_0, S_BL_DP, S_7);
`endif
        bus.valores = 16'h0000;
        bus.pontos  = 4'b0000;
`ifdef ZEROS_ESQUERDA_APAGA_EN
        quadro("f0000", S_BLANK, S_BLANK, S_BLANK, S_0);
`else
        quadro("f0000", S_0, S_0, S_0, S_0);
`endif

        // Drop ligado in the middle of digit 1's slot.
        bus.valores = 16'h1234;
        bus.pontos  = 4'b0100;
        slot("off/d0", 4'b0111, S_1, 1'b0);
        tick();
        pinos("off/d1dead", 4'b1111, S_BLANK, 1'b0);
        tick();
        pinos("off/d1", 4'b1011, S_2_DP, 1'b0);
        bus.ligado  = 1'b0;
        bus.valores = 16'h5678;
        repeat (5) begin
            tick();
            pinos("off/blank", 4'b1111, S_BLANK, 1'b0);
        end
        bus.ligado = 1'b1;

        // Restart picks up the new snapshot, then reset hits at idx=3, cnt=2.
        slot("on/d0", 4'b0111, S_5, 1'b0);
        slot("on/d1", 4'b1011, S_6_DP, 1'b0);
        slot("on/d2", 4'b1101, S_7, 1'b0);
        tick();
        pinos("on/d3dead", 4'b1111, S_BLANK, 1'b0);
        tick();
        pinos("on/d3", 4'b1110, S_8, 1'b0);
        reset = 1'b1;
        tick();
        pinos("abort", 4'b1111, S_BLANK, 1'b0);
        reset = 1'b0;
        quadro("after", S_5, S_6_DP, S_7, S_8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
